// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the 8-bit Wishbone peripheral bus initiator:
// default address/data widths, default ACK timeout and the FSM state encoding.
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 15;

  // State encoding of the initiator FSM.
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUS  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    BUS  = ST_BUS
  } wb_state_e;

endpackage : wb_pkg

// File: rtl/wb_timeout_cnt.sv
// ---------------------------------------------------------------------------
// wb_timeout_cnt
// Saturating cycle counter used to bound how long the initiator waits for ACK.
//   clk      in  system clock
//   rst      in  asynchronous active-low reset
//   clr      in  synchronous clear (start of a bus phase)
//   en       in  count one bus cycle without ACK
//   expired  out count has reached TIMEOUT-1, so the current edge is the last
//                one allowed; constant 0 when TIMEOUT = 0 (wait forever)
// ---------------------------------------------------------------------------
module wb_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CW'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_forever
      assign expired = 1'b0;
    end else begin : g_limit
      assign expired = (cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule : wb_timeout_cnt

// File: rtl/wb_initiator.sv
// ---------------------------------------------------------------------------
// wb_initiator
// Wishbone classic single-cycle bus master. Accepts one valid/ready request,
// runs one read or write on the bus, waits for ACK (bounded by TIMEOUT bus
// cycles, 0 = unbounded) and returns a one-cycle response strobe.
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_we/req_adr/req_dat    request direction, address, write data
//   rsp_valid                 one-cycle response strobe, no backpressure
//   rsp_dat                   read data (0 for writes and errors), held
//   rsp_err                   timeout error, qualified by rsp_valid
//   busy                      bus phase in progress
//   WB_*                      Wishbone classic master signals
// ---------------------------------------------------------------------------
module wb_initiator
  import wb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_adr,
  input  logic [DW-1:0] req_dat,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_dat,
  output logic          rsp_err,
  output logic          busy,
  output logic [AW-1:0] WB_ADRo,
  output logic [DW-1:0] WB_DATo,
  input  logic [DW-1:0] WB_DATi,
  output logic          WB_WEo,
  output logic          WB_CYCo,
  output logic          WB_STBo,
  input  logic          WB_ACKi
);

  wb_state_e state;
  logic      accept;
  logic      expired;

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      ((state == BUS) && !WB_ACKi),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      WB_ADRo   <= '0;
      WB_DATo   <= '0;
      WB_WEo    <= 1'b0;
      WB_CYCo   <= 1'b0;
      WB_STBo   <= 1'b0;
    end else begin
      // Response is a single-cycle strobe; rsp_dat alone holds its value.
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;

      case (state)
        IDLE: begin
          // ACK seen here is ignored: no cycle is open.
          if (req_valid) begin
            WB_ADRo <= req_adr;
            WB_DATo <= req_dat;
            WB_WEo  <= req_we;
            WB_CYCo <= 1'b1;
            WB_STBo <= 1'b1;
            busy    <= 1'b1;
            state   <= BUS;
          end
        end

        BUS: begin
          // ACK is tested first so it wins over a coincident timeout.
          if (WB_ACKi) begin
            WB_CYCo   <= 1'b0;
            WB_STBo   <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_dat   <= WB_WEo ? '0 : WB_DATi;
            state     <= IDLE;
          end else if (expired) begin
            WB_CYCo   <= 1'b0;
            WB_STBo   <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_dat   <= '0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : wb_initiator

// File: tb/tb_wb_initiator.sv
// ---------------------------------------------------------------------------
// tb_wb_initiator
// Self-checking bench for wb_initiator. A responder model drives ACK after a
// chosen number of wait states; the expected bus length, error flag and read
// data come from the transaction-level rule "ACK on STB cycle waits+1 unless
// that exceeds TIMEOUT cycles". A second instance with TIMEOUT = 0 checks the
// unbounded wait.
// ---------------------------------------------------------------------------
module tb_wb_initiator;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance with TIMEOUT = 15
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic          rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_dat;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_we, wb_cyc, wb_stb, wb_ack;

  // Instance with TIMEOUT = 0
  logic          z_req_valid, z_req_ready, z_req_we;
  logic [AW-1:0] z_req_adr;
  logic [DW-1:0] z_req_dat;
  logic          z_rsp_valid, z_rsp_err, z_busy;
  logic [DW-1:0] z_rsp_dat;
  logic [AW-1:0] z_wb_adr;
  logic [DW-1:0] z_wb_dat_o, z_wb_dat_i;
  logic          z_wb_we, z_wb_cyc, z_wb_stb, z_wb_ack;

  wb_initiator #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .busy(busy),
    .WB_ADRo(wb_adr), .WB_DATo(wb_dat_o), .WB_DATi(wb_dat_i), .WB_WEo(wb_we),
    .WB_CYCo(wb_cyc), .WB_STBo(wb_stb), .WB_ACKi(wb_ack)
  );

  wb_initiator #(.AW(AW), .DW(DW), .TIMEOUT(0)) dut_inf (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_adr(z_req_adr), .req_dat(z_req_dat),
    .rsp_valid(z_rsp_valid), .rsp_dat(z_rsp_dat), .rsp_err(z_rsp_err), .busy(z_busy),
    .WB_ADRo(z_wb_adr), .WB_DATo(z_wb_dat_o), .WB_DATi(z_wb_dat_i), .WB_WEo(z_wb_we),
    .WB_CYCo(z_wb_cyc), .WB_STBo(z_wb_stb), .WB_ACKi(z_wb_ack)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Starts at a negedge with the initiator idle; returns at the negedge of
  // the response cycle so a follow-on request can be issued immediately.
  task automatic do_txn(input logic we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] dat, input int waits,
                        input logic [DW-1:0] rdata);
    int   exp_len;
    logic exp_err;
    int   n;
    exp_err = (waits + 1 > TO);
    exp_len = exp_err ? TO : waits + 1;

    check("accept_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_adr   = AW'($urandom);
    req_dat   = DW'($urandom);

    n = 0;
    while (wb_cyc === 1'b1 && n < 40) begin
      n++;
      check("bus_stb", wb_stb, 1'b1);
      check("bus_adr", wb_adr, adr);
      check("bus_dat", wb_dat_o, dat);
      check("bus_we", wb_we, we);
      check("bus_busy", busy, 1'b1);
      check("bus_ready", req_ready, 1'b0);
      check("bus_no_rsp", rsp_valid, 1'b0);
      wb_ack   = (n == waits + 1);
      wb_dat_i = (n == waits + 1) ? rdata : DW'($urandom);
      @(negedge clk);
    end
    wb_ack = 1'b0;

    check("bus_len", n, exp_len);
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_dat", rsp_dat, (we || exp_err) ? '0 : rdata);
    check("end_cyc", wb_cyc, 1'b0);
    check("end_stb", wb_stb, 1'b0);
    check("end_busy", busy, 1'b0);
    check("end_ready", req_ready, 1'b1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("idle_no_rsp", rsp_valid, 1'b0);
      check("idle_cyc", wb_cyc, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0;
    wb_dat_i = '0; wb_ack = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_adr = '0; z_req_dat = '0;
    z_wb_dat_i = '0; z_wb_ack = 1'b0;

    // Reset values
    #2;
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_dat", rsp_dat, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_adr", wb_adr, '0);
    check("rst_dato", wb_dat_o, '0);
    check("rst_we", wb_we, 1'b0);
    check("rst_cyc", wb_cyc, 1'b0);
    check("rst_stb", wb_stb, 1'b0);
    check("rst_z_ready", z_req_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1. zero-wait write
    do_txn(1'b1, 8'h01, 8'hA5, 0, 8'h00);
    idle(1);
    check("hold_adr", wb_adr, 8'h01);
    check("hold_dato", wb_dat_o, 8'hA5);
    check("hold_we", wb_we, 1'b1);

    // 2. read with 3 wait states
    do_txn(1'b0, 8'h10, 8'h00, 3, 8'h3C);
    idle(2);
    check("hold_rsp_dat", rsp_dat, 8'h3C);

    // 3. timeout, ACK never arrives
    do_txn(1'b0, 8'h20, 8'h00, 30, 8'h55);
    idle(1);

    // 4. ACK on the expiry edge, and one cycle past it
    do_txn(1'b0, 8'h30, 8'h00, 14, 8'hC3);
    idle(1);
    do_txn(1'b0, 8'h31, 8'h00, 15, 8'hC4);
    idle(1);

    // 5. back-to-back, each accepted in its predecessor's response cycle
    do_txn(1'b1, 8'h40, 8'h11, 0, 8'h00);
    do_txn(1'b0, 8'h41, 8'h00, 2, 8'h5A);
    do_txn(1'b0, 8'h42, 8'h00, 0, 8'h6B);
    idle(1);

    // Unbounded wait with TIMEOUT = 0
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_adr = 8'h77; z_req_dat = 8'h00;
    @(negedge clk);
    z_req_valid = 1'b0;
    for (int i = 0; i < 120; i++) begin
      check("inf_cyc", z_wb_cyc, 1'b1);
      check("inf_no_rsp", z_rsp_valid, 1'b0);
      @(negedge clk);
    end
    z_wb_ack = 1'b1; z_wb_dat_i = 8'h7E;
    @(negedge clk);
    z_wb_ack = 1'b0;
    check("inf_rsp_valid", z_rsp_valid, 1'b1);
    check("inf_rsp_err", z_rsp_err, 1'b0);
    check("inf_rsp_dat", z_rsp_dat, 8'h7E);
    check("inf_cyc_end", z_wb_cyc, 1'b0);

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom), AW'($urandom), DW'($urandom),
             $urandom_range(0, 18), DW'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(1);

    // Stray ACK while idle
    wb_ack = 1'b1;
    idle(3);
    wb_ack = 1'b0;

    // 6. reset in the middle of a bus phase
    req_valid = 1'b1; req_we = 1'b0; req_adr = 8'h99; req_dat = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_cyc", wb_cyc, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_cyc", wb_cyc, 1'b0);
    check("arst_stb", wb_stb, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", req_ready, 1'b1);
    check("arst_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    wb_ack = 1'b1;
    idle(2);
    wb_ack = 1'b0;
    check("post_rst_ready", req_ready, 1'b1);
    do_txn(1'b0, 8'h99, 8'h00, 1, 8'hE7);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wb_initiator
